// File: rtl/datapath_pkg.sv
// Shared definitions for the sequenced datapath: operation codes, sequencer
// states and the quotient pattern produced by a divide-by-zero.
package datapath_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_ROL  = 4'd7;
    localparam logic [3:0] OP_NEG  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;
    localparam logic [3:0] OP_MFHI = 4'd12;
    localparam logic [3:0] OP_MFLO = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_T1    = 3'd1,
        ST_T2    = 3'd2,
        ST_TITER = 3'd3,
        ST_T3    = 3'd4
    } state_t;

    // Every quotient bit is this value when the divisor is zero.
    localparam logic DZ_QUOTIENT_BIT = 1'b1;

    function automatic logic isIterOp(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic isLegalOp(input logic [3:0] op);
        return op <= OP_MFLO;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// hi/lo show the result of the step in progress while busy, else the held result.
module muldiv_iter
    import datapath_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_div,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            busy,
    output logic            last,
    output logic [BITS-1:0] hi,
    output logic [BITS-1:0] lo,
    output logic            dz
);

    localparam int CW = $clog2(BITS);

    logic            busy_q;
    logic [CW-1:0]   count_q;
    logic            isDiv_q;
    logic [BITS-1:0] opnd_q;
    logic [BITS:0]   acc_q;
    logic [BITS-1:0] low_q;
    logic            dz_q;

    logic [BITS:0]   accStep;
    logic [BITS-1:0] lowStep;
    logic [BITS:0]   mulSum;
    logic [BITS:0]   remShift;
    logic [BITS:0]   trial;

    // Multiply: add multiplicand into the upper half when the low bit is set, then
    // shift right. Divide: shift remainder left, keep the trial subtract if it fits.
    always_comb begin
        mulSum   = low_q[0] ? (acc_q + {1'b0, opnd_q}) : acc_q;
        remShift = {acc_q[BITS-1:0], low_q[BITS-1]};
        trial    = remShift - {1'b0, opnd_q};
        accStep  = acc_q;
        lowStep  = low_q;
        if (isDiv_q) begin
            if (!trial[BITS]) begin
                accStep = trial;
                lowStep = {low_q[BITS-2:0], 1'b1};
            end else begin
                accStep = remShift;
                lowStep = {low_q[BITS-2:0], 1'b0};
            end
        end else begin
            accStep = {1'b0, mulSum[BITS:1]};
            lowStep = {mulSum[0], low_q[BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            count_q <= '0;
            isDiv_q <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            low_q   <= '0;
            dz_q    <= 1'b0;
        end else if (start) begin
            busy_q  <= 1'b1;
            count_q <= '0;
            isDiv_q <= is_div;
            opnd_q  <= b;
            acc_q   <= '0;
            low_q   <= a;
            dz_q    <= is_div && (b == '0);
        end else if (busy_q) begin
            acc_q   <= accStep;
            low_q   <= lowStep;
            count_q <= count_q + 1'b1;
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign last = busy_q && (count_q == CW'(BITS - 1));
    assign hi   = busy_q ? accStep[BITS-1:0] : acc_q[BITS-1:0];
    assign lo   = busy_q ? lowStep : low_q;
    assign dz   = dz_q;

endmodule

// File: rtl/datapath_seq.sv
// Single-bus datapath with an internal T-state sequencer: one accepted command
// runs R[ra] <- R[rb] op R[rc], or fills HI/LO through the iterative MUL/DIV unit.
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16,
    parameter int RW        = $clog2(REGISTERS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_op,
    input  logic [RW-1:0]   cmd_ra,
    input  logic [RW-1:0]   cmd_rb,
    input  logic [RW-1:0]   cmd_rc,
    output logic            done,
    output logic            err,
    output logic [BITS-1:0] hi_val,
    output logic [BITS-1:0] lo_val,
    input  logic [RW-1:0]   dbg_sel,
    output logic [BITS-1:0] dbg_data
);

    localparam int SHW = $clog2(BITS);

    state_t          state_q, state_d;
    logic [3:0]      op_q;
    logic [RW-1:0]   ra_q, rb_q, rc_q;
    logic [BITS-1:0] ry_q, ry_d;
    logic [BITS-1:0] rz_q, rz_d;
    logic [BITS-1:0] hi_q, lo_q;
    logic [BITS-1:0] regs_q [REGISTERS];
    logic            done_q, err_q;

    logic [BITS-1:0]   busVal, opB, aluOut;
    logic [SHW-1:0]    shamt;
    logic [2*BITS-1:0] rotR, rotL;
    logic              iterStart, iterBusy, iterLast, iterDz;
    logic [BITS-1:0]   iterHi, iterLo;
    logic              regWe, hiloWe, accept;

    assign busVal = regs_q[rb_q];
    assign opB    = regs_q[rc_q];
    assign shamt  = opB[SHW-1:0];
    assign accept = cmd_valid && cmd_ready;

    // Rotates use a doubled copy of RY so the wrapped bits fall out of one shift.
    always_comb begin
        rotR   = {ry_q, ry_q} >> shamt;
        rotL   = {ry_q, ry_q} << shamt;
        aluOut = ry_q;
        case (op_q)
            OP_ADD:  aluOut = ry_q + opB;
            OP_SUB:  aluOut = ry_q - opB;
            OP_AND:  aluOut = ry_q & opB;
            OP_OR:   aluOut = ry_q | opB;
            OP_SHR:  aluOut = ry_q >> shamt;
            OP_SHL:  aluOut = ry_q << shamt;
            OP_ROR:  aluOut = rotR[BITS-1:0];
            OP_ROL:  aluOut = rotL[2*BITS-1:BITS];
            OP_NEG:  aluOut = {BITS{1'b0}} - ry_q;
            OP_NOT:  aluOut = ~ry_q;
            OP_MFHI: aluOut = hi_q;
            OP_MFLO: aluOut = lo_q;
            default: aluOut = ry_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ry_d      = ry_q;
        rz_d      = rz_q;
        iterStart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_T1;
            end
            ST_T1: begin
                ry_d = busVal;
                if (isIterOp(op_q)) begin
                    iterStart = 1'b1;
                    state_d   = ST_TITER;
                end else begin
                    state_d = ST_T2;
                end
            end
            ST_T2: begin
                rz_d    = aluOut;
                state_d = ST_T3;
            end
            ST_TITER: begin
                if (iterLast) begin
                    rz_d    = iterLo;
                    state_d = ST_T3;
                end
            end
            ST_T3:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign regWe  = (state_q == ST_T3) && isLegalOp(op_q) && !isIterOp(op_q);
    assign hiloWe = (state_q == ST_T3) && isIterOp(op_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            ry_q    <= '0;
            rz_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ry_q    <= ry_d;
            rz_q    <= rz_d;
            if (accept) begin
                op_q <= cmd_op;
                ra_q <= cmd_ra;
                rb_q <= cmd_rb;
                rc_q <= cmd_rc;
            end
            if (hiloWe) begin
                hi_q <= iterHi;
                lo_q <= iterDz ? {BITS{DZ_QUOTIENT_BIT}} : iterLo;
            end
            done_q <= (state_q == ST_T3);
            err_q  <= (state_q == ST_T3) &&
                      (!isLegalOp(op_q) || ((op_q == OP_DIV) && iterDz));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGISTERS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (regWe) begin
            regs_q[ra_q] <= rz_q;
        end
    end

    muldiv_iter #(.BITS(BITS)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (iterStart),
        .is_div (op_q == OP_DIV),
        .a      (busVal),
        .b      (opB),
        .busy   (iterBusy),
        .last   (iterLast),
        .hi     (iterHi),
        .lo     (iterLo),
        .dz     (iterDz)
    );

    assign cmd_ready = (state_q == ST_IDLE) && !iterBusy;
    assign done      = done_q;
    assign err       = err_q;
    assign hi_val    = hi_q;
    assign lo_val    = lo_q;
    assign dbg_data  = regs_q[dbg_sel];

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: register contents are built with ALU commands
// from the all-zero reset state, then each scenario checks against hand values.
module tb_datapath_seq;
    import datapath_pkg::*;

    localparam int BITS      = 32;
    localparam int REGISTERS = 16;
    localparam int RW        = 4;
    localparam logic [RW-1:0] ONE_REG  = 4'd14;
    localparam logic [RW-1:0] ONES_REG = 4'd15;

    logic            clk;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3:0]      cmd_op;
    logic [RW-1:0]   cmd_ra, cmd_rb, cmd_rc;
    logic            done, err;
    logic [BITS-1:0] hi_val, lo_val;
    logic [RW-1:0]   dbg_sel;
    logic [BITS-1:0] dbg_data;

    int checks = 0;
    int fails  = 0;

    datapath_seq #(.BITS(BITS), .REGISTERS(REGISTERS)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_rc    (cmd_rc),
        .done      (done),
        .err       (err),
        .hi_val    (hi_val),
        .lo_val    (lo_val),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Issues one command and counts clock edges from the accept edge to done.
    task automatic applyStimulus(input logic [3:0] op, input logic [RW-1:0] ra,
                                 input logic [RW-1:0] rb, input logic [RW-1:0] rc,
                                 output int edges, output logic errSeen,
                                 output logic readyAtDone, output logic readyLowBusy);
        int waitCnt;
        edges = 0; errSeen = 1'b0; readyAtDone = 1'b0; readyLowBusy = 1'b1;
        waitCnt = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc;
        while (!cmd_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!cmd_ready) begin
            checks++; fails++;
            $display("[TB] FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (done) begin
                errSeen     = err;
                readyAtDone = cmd_ready;
                break;
            end
            if (cmd_ready) readyLowBusy = 1'b0;
        end
        if (!done) begin
            checks++; fails++;
            $display("[TB] FAIL done_timeout: done=%b required 1 within 200 cycles", done);
        end
    endtask

    task automatic readReg(input logic [RW-1:0] idx, output logic [BITS-1:0] val);
        dbg_sel = idx;
        #1;
        val = dbg_data;
    endtask

    // Builds a constant MSB-first from R0 (always zero) and the unit register.
    task automatic loadConst(input logic [RW-1:0] ra, input logic [BITS-1:0] value);
        int e; logic er, rd, rl, started;
        started = 1'b0;
        applyStimulus(OP_SUB, ra, 4'd0, 4'd0, e, er, rd, rl);
        for (int i = BITS - 1; i >= 0; i--) begin
            if (started) applyStimulus(OP_SHL, ra, ra, ONE_REG, e, er, rd, rl);
            if (value[i]) begin
                applyStimulus(OP_ADD, ra, ra, ONE_REG, e, er, rd, rl);
                started = 1'b1;
            end
        end
    endtask

    task automatic initConsts();
        int e; logic er, rd, rl; logic [BITS-1:0] v;
        applyStimulus(OP_NOT, ONES_REG, 4'd0, 4'd0, e, er, rd, rl);
        applyStimulus(OP_NEG, ONE_REG, ONES_REG, 4'd0, e, er, rd, rl);
        readReg(ONE_REG, v);
        checks++;
        if (v !== 32'h1) begin
            fails++;
            $display("[TB] FAIL init_one: got %h required %h", v, 32'h1);
        end
    endtask

    task automatic test_reset();
        logic [BITS-1:0] v;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: ready/done/err=%b%b%b required 100", cmd_ready, done, err);
        end
        checks++;
        if (hi_val !== '0 || lo_val !== '0) begin
            fails++;
            $display("[TB] FAIL reset_hilo: hi=%h lo=%h required 0", hi_val, lo_val);
        end
        for (int i = 0; i < REGISTERS; i++) begin
            readReg(RW'(i), v);
            checks++;
            if (v !== '0) begin
                fails++;
                $display("[TB] FAIL reset_reg%0d: got %h required 0", i, v);
            end
        end
    endtask

    task automatic test_add();
        int e; logic er, rd, rl; logic [BITS-1:0] v;
        loadConst(4'd1, 32'd5);
        loadConst(4'd2, 32'd7);
        readReg(4'd1, v);
        checks++;
        if (v !== 32'd5) begin fails++; $display("[TB] FAIL load_r1: got %h required %h", v, 32'd5); end
        readReg(4'd2, v);
        checks++;
        if (v !== 32'd7) begin fails++; $display("[TB] FAIL load_r2: got %h required %h", v, 32'd7); end
        applyStimulus(OP_ADD, 4'd3, 4'd1, 4'd2, e, er, rd, rl);
        checks++;
        if (e !== 3) begin fails++; $display("[TB] FAIL add_latency: got %0d required 3", e); end
        checks++;
        if (er !== 1'b0 || rd !== 1'b1) begin
            fails++;
            $display("[TB] FAIL add_done_flags: err=%b ready=%b required err=0 ready=1", er, rd);
        end
        readReg(4'd3, v);
        checks++;
        if (v !== 32'h0000000C) begin fails++; $display("[TB] FAIL add_r3: got %h required %h", v, 32'h0000000C); end
    endtask

    task automatic test_sub_ror();
        int e; logic er, rd, rl; logic [BITS-1:0] v;
        loadConst(4'd1, 32'd0);
        loadConst(4'd2, 32'd1);
        applyStimulus(OP_SUB, 4'd4, 4'd1, 4'd2, e, er, rd, rl);
        readReg(4'd4, v);
        checks++;
        if (v !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL sub_r4: got %h required %h", v, 32'hFFFFFFFF); end
        loadConst(4'd1, 32'h1);
        loadConst(4'd2, 32'h21);
        applyStimulus(OP_ROR, 4'd6, 4'd1, 4'd2, e, er, rd, rl);
        readReg(4'd6, v);
        checks++;
        if (v !== 32'h80000000) begin fails++; $display("[TB] FAIL ror_r6: got %h required %h", v, 32'h80000000); end
    endtask

    // R1=0x800000F1, R2=0x00000F24 (shift amount 4).
    task automatic test_alu_table();
        int e; logic er, rd, rl; logic [BITS-1:0] v;
        logic [3:0]      ops  [7];
        logic [BITS-1:0] exps [7];
        ops[0] = OP_AND; exps[0] = 32'h00000020;
        ops[1] = OP_OR;  exps[1] = 32'h80000FF5;
        ops[2] = OP_SHR; exps[2] = 32'h0800000F;
        ops[3] = OP_SHL; exps[3] = 32'h00000F10;
        ops[4] = OP_ROL; exps[4] = 32'h00000F18;
        ops[5] = OP_NEG; exps[5] = 32'h7FFFFF0F;
        ops[6] = OP_NOT; exps[6] = 32'h7FFFFF0E;
        loadConst(4'd1, 32'h800000F1);
        loadConst(4'd2, 32'h00000F24);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(ops[i], 4'd7, 4'd1, 4'd2, e, er, rd, rl);
            readReg(4'd7, v);
            checks++;
            if (v !== exps[i] || er !== 1'b0) begin
                fails++;
                $display("[TB] FAIL alu_op%0d: got %h err=%b required %h err=0", ops[i], v, er, exps[i]);
            end
        end
    endtask

    task automatic test_mul();
        int e; logic er, rd, rl; logic [BITS-1:0] v;
        applyStimulus(OP_NOT, 4'd1, 4'd0, 4'd0, e, er, rd, rl);
        loadConst(4'd2, 32'd2);
        applyStimulus(OP_MUL, 4'd9, 4'd1, 4'd2, e, er, rd, rl);
        checks++;
        if (e !== 34 || rl !== 1'b1 || er !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mul_timing: edges=%0d readyLow=%b err=%b required 34 1 0", e, rl, er);
        end
        checks++;
        if (hi_val !== 32'h1 || lo_val !== 32'hFFFFFFFE) begin
            fails++;
            $display("[TB] FAIL mul_hilo: hi=%h lo=%h required 00000001 fffffffe", hi_val, lo_val);
        end
        readReg(4'd9, v);
        checks++;
        if (v !== '0) begin fails++; $display("[TB] FAIL mul_no_write: got %h required 0", v); end
        applyStimulus(OP_MFLO, 4'd5, 4'd0, 4'd0, e, er, rd, rl);
        readReg(4'd5, v);
        checks++;
        if (v !== 32'hFFFFFFFE) begin fails++; $display("[TB] FAIL mflo_r5: got %h required fffffffe", v); end
        applyStimulus(OP_MFHI, 4'd6, 4'd0, 4'd0, e, er, rd, rl);
        readReg(4'd6, v);
        checks++;
        if (v !== 32'h1) begin fails++; $display("[TB] FAIL mfhi_r6: got %h required 00000001", v); end
    endtask

    task automatic test_div();
        int e; logic er, rd, rl; logic [BITS-1:0] v;
        loadConst(4'd1, 32'd7);
        loadConst(4'd2, 32'd0);
        applyStimulus(OP_DIV, 4'd9, 4'd1, 4'd2, e, er, rd, rl);
        checks++;
        if (e !== 34 || er !== 1'b1) begin
            fails++;
            $display("[TB] FAIL div0_done: edges=%0d err=%b required 34 1", e, er);
        end
        checks++;
        if (lo_val !== 32'hFFFFFFFF || hi_val !== 32'd7) begin
            fails++;
            $display("[TB] FAIL div0_hilo: hi=%h lo=%h required 00000007 ffffffff", hi_val, lo_val);
        end
        readReg(4'd9, v);
        checks++;
        if (v !== '0) begin fails++; $display("[TB] FAIL div_no_write: got %h required 0", v); end
        loadConst(4'd2, 32'd2);
        applyStimulus(OP_DIV, 4'd9, 4'd1, 4'd2, e, er, rd, rl);
        checks++;
        if (er !== 1'b0 || lo_val !== 32'd3 || hi_val !== 32'd1) begin
            fails++;
            $display("[TB] FAIL div7_2: err=%b hi=%h lo=%h required 0 00000001 00000003", er, hi_val, lo_val);
        end
        applyStimulus(OP_NOT, 4'd1, 4'd0, 4'd0, e, er, rd, rl);
        loadConst(4'd2, 32'h10);
        applyStimulus(OP_DIV, 4'd9, 4'd1, 4'd2, e, er, rd, rl);
        checks++;
        if (lo_val !== 32'h0FFFFFFF || hi_val !== 32'hF) begin
            fails++;
            $display("[TB] FAIL div_max: hi=%h lo=%h required 0000000f 0fffffff", hi_val, lo_val);
        end
    endtask

    task automatic test_reset_midop();
        logic [BITS-1:0] v;
        logic doneSeen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_MUL; cmd_ra = 4'd9; cmd_rb = 4'd1; cmd_rc = 4'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (hi_val !== '0 || lo_val !== '0) begin
            fails++;
            $display("[TB] FAIL midop_hilo: hi=%h lo=%h required 0", hi_val, lo_val);
        end
        for (int i = 0; i < REGISTERS; i++) begin
            readReg(RW'(i), v);
            checks++;
            if (v !== '0) begin
                fails++;
                $display("[TB] FAIL midop_reg%0d: got %h required 0", i, v);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        doneSeen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) doneSeen = 1'b1;
        end
        checks++;
        if (doneSeen !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midop_after: doneSeen=%b ready=%b required 0 1", doneSeen, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [BITS-1:0] v;
        initConsts();
        loadConst(4'd1, 32'd5);
        loadConst(4'd2, 32'd7);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_ra = 4'd3; cmd_rb = 4'd1; cmd_rc = 4'd2;
        checks++;
        if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_idle_ready: got %b required 1", cmd_ready); end
        @(posedge clk); #1;
        cmd_op = 4'd15; cmd_ra = 4'd1;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_first_done: done/err/ready=%b%b%b required 101", done, err, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_second_accept: done/ready=%b%b required 00", done, cmd_ready);
        end
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_illegal_done: done/err=%b%b required 11", done, err);
        end
        readReg(4'd1, v);
        checks++;
        if (v !== 32'd5) begin fails++; $display("[TB] FAIL illegal_r1: got %h required 00000005", v); end
        readReg(4'd3, v);
        checks++;
        if (v !== 32'h0000000C) begin fails++; $display("[TB] FAIL b2b_r3: got %h required 0000000c", v); end
        checks++;
        if (hi_val !== '0 || lo_val !== '0) begin
            fails++;
            $display("[TB] FAIL illegal_hilo: hi=%h lo=%h required 0", hi_val, lo_val);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_ra    = '0;
        cmd_rb    = '0;
        cmd_rc    = '0;
        dbg_sel   = '0;
        $display("[TB] starting datapath_seq bench");
        test_reset();
        initConsts();
        test_add();
        test_sub_ror();
        test_alu_table();
        test_mul();
        test_div();
        test_reset_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
